// File: rtl/mul_seq_ctrl.sv
// Radix-2 shift-add sequencer for SMUL: one multiplier bit per clock, with a
// stall request to the core while running and a registered 2*WIDTH-bit product.
module mul_seq_ctrl #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             oStall,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultLo,
  output logic [WIDTH-1:0] oResultHi
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [WIDTH-1:0]   mplier, mplier_shift;
  logic [CW-1:0]      count;
  logic               accept, last;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of block ordering.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal driven here gets a default first so no path through the
  // case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    acc_next     = acc + (mplier[0] ? mcand : '0);
    mplier_shift = mplier >> 1;
    last         = (count == CW'(WIDTH - 1)) ||
                   ((EARLY_EXIT != 0) && (mplier_shift == '0));
    unique case (state)
      IDLE, DONE: begin
        if (iStart) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN:     if (last) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Start acceptance ignores iStart in RUN, so the in-flight operands are
  // untouched by anything the core does while stalled.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
      oResultLo <= '0;
      oResultHi <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, iA};
      mplier <= iB;
      acc    <= '0;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier_shift;
      count  <= count + CW'(1);
      if (last) {oResultHi, oResultLo} <= acc_next;
    end
  end

  // Stall asserts in the issue cycle and drops in DONE so write-back proceeds.
  assign oBusy  = (state == RUN);
  assign oDone  = (state == DONE);
  assign oStall = (state == RUN) || (iStart && (state != RUN));

endmodule
